// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the single-cycle MIPS core.
// Services byte/half/word stores (committed on the clock edge) and
// combinational loads. After reset, a scrub pass zeroes the RAM.
// Optional MMIO window (cycle counter, LED register) is enabled by
// defining DM_MMIO_EN.
module dm_responder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        MemWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              ready,
    output logic              misalign,
    output logic [15:0]       led,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_BYTE = 2'b11;

    typedef enum logic {
        S_SCRUB = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       mem_q [DEPTH];

    logic [ADDR_W-1:0] idx_c;
    logic [4:0]        shamt_c;
    logic [31:0]       rd_word_c;
    logic              run_c;
    logic              in_win_c;
    logic              win_bad_c;
    logic [31:0]       mmio_rdata_c;

    logic              st_legal_c;
    logic              st_bad_c;
    logic [31:0]       lane_mask_c;
    logic [31:0]       lane_data_c;
    logic [31:0]       merged_c;
    logic              ram_we_c;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_widx_c;
    logic [31:0]       mem_wdata_c;

    assign idx_c     = addr[ADDR_W+1:2];
    assign shamt_c   = {addr[1:0], 3'b000};
    assign rd_word_c = mem_q[idx_c];
    assign run_c     = (state_q == S_RUN);

`ifdef DM_MMIO_EN
    logic [31:0] cyc_q, cyc_d;
    logic [15:0] led_q, led_d;

    assign in_win_c  = (addr[31:28] == 4'hF);
    assign win_bad_c = in_win_c && ((MemWrite == MW_HALF) || (MemWrite == MW_BYTE));

    // MMIO register next-state: free-running counter, LED loaded by word store
    always_comb begin
        cyc_d = cyc_q + 32'd1;
        led_d = led_q;
        if (run_c && (MemWrite == MW_WORD) && (addr == 32'hF000_0004)) begin
            led_d = writedata[15:0];
        end
    end

    // MMIO registers reset only on rst, never by the scrub
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= 32'd0;
            led_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
            led_q <= led_d;
        end
    end

    // MMIO read mux; unmapped window addresses read zero
    always_comb begin
        mmio_rdata_c = 32'd0;
        if (addr == 32'hF000_0000) begin
            mmio_rdata_c = cyc_q;
        end else if (addr == 32'hF000_0004) begin
            mmio_rdata_c = {16'h0000, led_q};
        end
    end

    assign led = led_q;
`else
    logic unused_addr_c;

    assign in_win_c      = 1'b0;
    assign win_bad_c     = 1'b0;
    assign mmio_rdata_c  = 32'd0;
    assign led           = 16'd0;
    // High address bits only matter for the MMIO decode
    assign unused_addr_c = ^addr[31:ADDR_W+2];
`endif

    // Store decode: legality, lane mask and lane-aligned data
    always_comb begin
        st_legal_c  = 1'b0;
        lane_mask_c = 32'd0;
        lane_data_c = 32'd0;
        unique case (MemWrite)
            MW_WORD: begin
                st_legal_c  = (addr[1:0] == 2'b00);
                lane_mask_c = 32'hFFFF_FFFF;
                lane_data_c = writedata;
            end
            MW_HALF: begin
                st_legal_c  = ~addr[0];
                lane_mask_c = 32'h0000_FFFF << shamt_c;
                lane_data_c = {16'h0000, writedata[15:0]} << shamt_c;
            end
            MW_BYTE: begin
                st_legal_c  = 1'b1;
                lane_mask_c = 32'h0000_00FF << shamt_c;
                lane_data_c = {24'h00_0000, writedata[7:0]} << shamt_c;
            end
            default: ;
        endcase
        st_bad_c = (MemWrite != MW_NONE) && !st_legal_c;
        merged_c = (rd_word_c & ~lane_mask_c) | (lane_data_c & lane_mask_c);
        ram_we_c = (MemWrite != MW_NONE) && st_legal_c && !in_win_c;
    end

    // Next-state: scrub walks every word, then RUN services core stores
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        misalign_d  = misalign_q;
        mem_we_c    = 1'b0;
        mem_widx_c  = idx_c;
        mem_wdata_c = merged_c;
        unique case (state_q)
            S_SCRUB: begin
                mem_we_c    = 1'b1;
                mem_widx_c  = ptr_q;
                mem_wdata_c = 32'd0;
                ptr_d       = ptr_q + ADDR_W'(1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                mem_we_c = ram_we_c;
                if (st_bad_c || win_bad_c) begin
                    misalign_d = 1'b1;
                end
            end
            default: state_d = S_SCRUB;
        endcase
    end

    // State, scrub pointer and sticky misalign flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_SCRUB;
            ptr_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            misalign_q <= misalign_d;
        end
    end

    // RAM write port; contents are cleared by the scrub rather than by reset
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_widx_c] <= mem_wdata_c;
        end
    end

    // Combinational load path, right-justified to the addressed lane
    always_comb begin
        readdata = 32'd0;
        if (run_c) begin
            if (in_win_c) begin
                readdata = mmio_rdata_c;
            end else begin
                readdata = rd_word_c >> shamt_c;
            end
        end
    end

    assign dbg_data = run_c ? mem_q[dbg_addr] : 32'd0;
    assign ready    = run_c;
    assign misalign = misalign_q;

endmodule
